// File: rtl/gauss_poly_collect.sv
// Collects N = 2^logn accepted Gaussian samples as signed 8-bit coefficients, enforcing range and odd-sum parity.
// Define GAUSS_POLY_NORM_EN to build the squared-norm accumulator; otherwise sq_norm is tied to zero.
module gauss_poly_collect #(
  parameter int logn = 9
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            in_valid,
  input  logic [31:0]     in_val,
  output logic            need,
  output logic            busy,
  output logic            done,
  output logic [15:0]     rej_cnt,
  input  logic [logn-1:0] rd_addr,
  output logic [7:0]      rd_data,
  output logic [31:0]     sq_norm
);

  localparam int N = 1 << logn;

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

  state_t          state, state_nx;
  logic [logn-1:0] idx;
  logic            mod2;
  logic [7:0]      mem [N];

  logic sample_en, in_range, is_last, parity_ok, accept, reject;

  always_comb begin
    sample_en = (state == COLLECT) && in_valid && !start;
    in_range  = ($signed(in_val) >= -32'sd127) && ($signed(in_val) <= 32'sd127);
    is_last   = &idx;
    // Only the final slot is constrained: it must make the coefficient sum odd.
    parity_ok = !is_last || (mod2 ^ in_val[0]);
    accept    = sample_en && in_range && parity_ok;
    reject    = sample_en && !accept;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = IDLE;
      COLLECT: if (accept && is_last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (start) state_nx = COLLECT;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx     <= '0;
      mod2    <= 1'b0;
      rej_cnt <= '0;
    end else if (start) begin
      idx     <= '0;
      mod2    <= 1'b0;
      rej_cnt <= '0;
    end else if (accept) begin
      idx  <= idx + logn'(1);
      mod2 <= mod2 ^ in_val[0];
    end else if (reject && (rej_cnt != 16'hFFFF)) begin
      rej_cnt <= rej_cnt + 16'd1;
    end
  end

  // Coefficient store is deliberately not reset; readers only trust it after done.
  always_ff @(posedge clk) begin
    if (accept) mem[idx] <= in_val[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

`ifdef GAUSS_POLY_NORM_EN
  logic signed [15:0] sq_term;
  logic [31:0]        sq_acc;

  assign sq_term = $signed(in_val[7:0]) * $signed(in_val[7:0]);

  always_ff @(posedge clk) begin
    if (rst || start) sq_acc <= '0;
    else if (accept)  sq_acc <= sq_acc + {16'd0, sq_term};
  end

  assign sq_norm = sq_acc;
`else
  assign sq_norm = '0;
`endif

  assign need = (state == COLLECT);
  assign busy = need;
  assign done = (state == DONE);

endmodule

// File: tb/tb_gauss_poly_collect.sv
// Self-checking bench for gauss_poly_collect: three instances (logn 2, 3, 9) driven one at a time against
// a behavioural model, plus literal expectations from hand-worked vectors.
module tb_gauss_poly_collect;

`ifdef GAUSS_POLY_NORM_EN
  localparam bit NORM = 1'b1;
`else
  localparam bit NORM = 1'b0;
`endif
  localparam int LGS [3] = '{2, 3, 9};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [2:0]      start_v, iv_v;
  logic [2:0][31:0] val_v;
  logic [2:0][9:0] addr_v;
  logic [2:0]      need_v, busy_v, done_v;
  logic [2:0][15:0] rej_v;
  logic [2:0][7:0] rd_v;
  logic [2:0][31:0] sq_v;

  for (genvar k = 0; k < 3; k++) begin : g_dut
    gauss_poly_collect #(.logn(LGS[k])) u_dut (
      .clk(clk), .rst(rst), .start(start_v[k]), .in_valid(iv_v[k]), .in_val(val_v[k]),
      .need(need_v[k]), .busy(busy_v[k]), .done(done_v[k]), .rej_cnt(rej_v[k]),
      .rd_addr(addr_v[k][LGS[k]-1:0]), .rd_data(rd_v[k]), .sq_norm(sq_v[k]));
  end

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;
  int sel = 0;
  int n_m = 4;
  bit chk_en = 1'b0;

  // Model state: what the outputs must be, from the acceptance rules alone.
  bit          coll_m, done_m, par_m, rdv_m;
  int          cnt_m, rej_m;
  longint      sq_m;
  logic [7:0]  exp_rd;
  logic [7:0]  mm [3][1024];
  bit          vv [3][1024];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin : model
    int s, a;
    if (rst) begin
      coll_m = 0; done_m = 0; rej_m = 0; sq_m = 0; exp_rd = 8'd0; rdv_m = 1;
    end else begin
      a      = int'(addr_v[sel]) & (n_m - 1);
      exp_rd = mm[sel][a];
      rdv_m  = vv[sel][a];
      done_m = 0;
      s      = $signed(val_v[sel]);
      if (start_v[sel]) begin
        coll_m = 1; cnt_m = 0; par_m = 0; rej_m = 0; sq_m = 0;
      end else if (coll_m && iv_v[sel]) begin
        if (s >= -127 && s <= 127 && !(cnt_m == n_m - 1 && (par_m ^ s[0]) == 1'b0)) begin
          mm[sel][cnt_m] = s[7:0];
          vv[sel][cnt_m] = 1;
          cnt_m++;
          par_m ^= s[0];
          sq_m += longint'(s * s);
          if (cnt_m == n_m) begin
            coll_m = 0;
            done_m = 1;
          end
        end else if (rej_m < 65535) begin
          rej_m++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("need", 64'(need_v[sel]), 64'(coll_m));
      checkOutput("busy", 64'(busy_v[sel]), 64'(coll_m));
      checkOutput("done", 64'(done_v[sel]), 64'(done_m));
      checkOutput("rej_cnt", 64'(rej_v[sel]), 64'(rej_m));
      checkOutput("sq_norm", 64'(sq_v[sel]), NORM ? 64'(sq_m) : 64'd0);
      if (rdv_m) checkOutput("rd_data", 64'(rd_v[sel]), 64'(exp_rd));
      if (done_v[sel]) done_cnt++;
    end
  end

  task automatic applyStimulus(input bit st, input bit v, input int val);
    start_v[sel] = st;
    iv_v[sel]    = v;
    val_v[sel]   = val;
    @(posedge clk); #1;
    start_v[sel] = 1'b0;
    iv_v[sel]    = 1'b0;
  endtask

  task automatic selectDut(input int k);
    chk_en = 1'b0;
    sel    = k;
    n_m    = 1 << LGS[k];
    rst    = 1'b1;
    @(posedge clk); #1;
    rst      = 1'b0;
    done_cnt = 0;
    chk_en   = 1'b1;
  endtask

  task automatic readCheck(input string name, input int addr, input int exp);
    logic [7:0] e;
    e = exp[7:0];
    addr_v[sel] = addr[9:0];
    @(posedge clk); #1;
    checkOutput(name, 64'(rd_v[sel]), 64'(e));
  endtask

  task automatic feed(input int vals []);
    foreach (vals[i]) applyStimulus(1'b0, 1'b1, vals[i]);
  endtask

  initial begin
    int bad, sum, cyc, smp;
    bit v;
    logic [7:0] r;
    rst = 1'b0; start_v = '0; iv_v = '0; val_v = '0; addr_v = '0;

    // Reset values
    selectDut(0);
    checkOutput("rst_need", 64'(need_v[0]), 0);
    checkOutput("rst_done", 64'(done_v[0]), 0);
    checkOutput("rst_rej", 64'(rej_v[0]), 0);
    checkOutput("rst_sq", 64'(sq_v[0]), 0);
    checkOutput("rst_rd", 64'(rd_v[0]), 0);

    // Parity rejection on the last slot, logn=2
    applyStimulus(1'b1, 1'b0, 0);
    checkOutput("t1_need", 64'(need_v[0]), 1);
    feed('{3, -1, 0, 2, 5});
    checkOutput("t1_done", 64'(done_v[0]), 1);
    checkOutput("t1_rej", 64'(rej_v[0]), 1);
    checkOutput("t1_sq", 64'(sq_v[0]), NORM ? 35 : 0);
    applyStimulus(1'b0, 1'b0, 0);
    checkOutput("t1_done_fall", 64'(done_v[0]), 0);
    readCheck("t1_rd0", 0, 3);
    readCheck("t1_rd1", 1, -1);
    readCheck("t1_rd2", 2, 0);
    readCheck("t1_rd3", 3, 5);

    // Range boundaries, logn=2
    selectDut(0);
    applyStimulus(1'b1, 1'b0, 0);
    feed('{-128, 128, 200, -127, 127, 0, 1});
    checkOutput("t2_done", 64'(done_v[0]), 1);
    checkOutput("t2_rej", 64'(rej_v[0]), 3);
    checkOutput("t2_sq", 64'(sq_v[0]), NORM ? 32259 : 0);
    readCheck("t2_rd0", 0, -127);
    readCheck("t2_rd1", 1, 127);
    readCheck("t2_rd2", 2, 0);
    readCheck("t2_rd3", 3, 1);

    // Restart mid-collection, logn=3
    selectDut(1);
    applyStimulus(1'b1, 1'b0, 0);
    feed('{1, 2, 300, 3, 4, 5});
    checkOutput("t3_rej_first", 64'(rej_v[1]), 1);
    applyStimulus(1'b1, 1'b1, 77);
    checkOutput("t3_rej_cleared", 64'(rej_v[1]), 0);
    feed('{7, -7, 6, -6, -200, 10, 0, 2, 4, 9});
    checkOutput("t3_rej", 64'(rej_v[1]), 2);
    checkOutput("t3_sq", 64'(sq_v[1]), NORM ? 355 : 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 0);
    checkOutput("t3_one_done", 64'(done_cnt), 1);
    readCheck("t3_rd0", 0, 7);
    readCheck("t3_rd4", 4, 10);
    readCheck("t3_rd7", 7, 9);

    // Ignored samples in IDLE, then abort by reset
    selectDut(1);
    feed('{500, 3, -300});
    checkOutput("t4_idle_rej", 64'(rej_v[1]), 0);
    applyStimulus(1'b1, 1'b0, 0);
    feed('{1, 900, 2, 3});
    checkOutput("t4_rej_pre", 64'(rej_v[1]), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checkOutput("t4_abort_need", 64'(need_v[1]), 0);
    checkOutput("t4_abort_rej", 64'(rej_v[1]), 0);
    checkOutput("t4_abort_sq", 64'(sq_v[1]), 0);
    checkOutput("t4_abort_rd", 64'(rd_v[1]), 0);
    repeat (10) applyStimulus(1'b0, 1'b1, 1);
    checkOutput("t4_no_done", 64'(done_cnt), 0);

    // logn=9 stream with gaps and a 300-sample back-to-back burst
    selectDut(2);
    applyStimulus(1'b1, 1'b0, 0);
    cyc = 0;
    while (done_cnt == 0 && cyc < 20000) begin
      v = (cyc >= 100 && cyc < 400) ? 1'b1 : ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 15) == 0) smp = 128 + int'($urandom_range(0, 60));
      else                            smp = int'($urandom_range(0, 60)) - 30;
      if ($urandom_range(0, 1) == 1 && smp > 30) smp = -smp;
      applyStimulus(1'b0, v, smp);
      cyc++;
    end
    checkOutput("t5_done_seen", 64'(done_cnt), 1);
    bad = 0;
    sum = 0;
    for (int a = 0; a < 512; a++) begin
      addr_v[2] = a[9:0];
      @(posedge clk); #1;
      r = rd_v[2];
      sum += int'($signed(r));
      if (r == 8'h80) bad++;
    end
    checkOutput("t5_range", 64'(bad), 0);
    checkOutput("t5_sum_odd", 64'(sum & 1), 1);

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gauss_poly_collect.md
# gauss_poly_collect

Downstream consumer of the Gaussian sampler in the key-generation path. Accepts the stream of signed samples the sampler emits and applies the small-polynomial acceptance rules: range check and odd-sum parity on the last coefficient. Stores N = 2^logn accepted coefficients as signed 8-bit values and signals completion. The buffer is then read out by the next keygen stage, the f/g polynomial consumer.

## Interface

- logn, default 9: polynomial degree exponent; N = 1 << logn; legal 1..10.
- clk  in  1: clock, all logic on rising edge.
- rst  in  1: reset, synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1: one-cycle pulse, begins a new polynomial; honoured in every state.
- in_valid  in  1: sample strobe from the Gaussian sampler (its out_valid).
- in_val  in  32: signed two's-complement sample (the sampler's val).
- need  out  1: high while collecting; upstream gates its RNG with it.
- busy  out  1: equals need.
- done  out  1: one-cycle pulse when N coefficients are stored.
- rej_cnt  out  16: rejected samples since last start; saturates at 16'hFFFF.
- rd_addr  in  logn: readout address.
- rd_data  out  8: signed coefficient at rd_addr, registered.
- sq_norm  out  32: sum of squares of accepted coefficients (see Configuration).

## Operation

- States: IDLE, COLLECT, DONE.
- IDLE -> COLLECT on start. COLLECT -> DONE on acceptance of coefficient N-1. DONE -> IDLE after one cycle. Any state -> COLLECT on start.
- start clears idx, mod2, rej_cnt and sq_norm. Buffer contents are not cleared.
- In COLLECT, with in_valid high and start low, the sample s is evaluated:
  - Range: reject if s < -127 or s > 127 (32-bit signed compare).
  - Parity, last slot only (idx == N-1): reject if (mod2 XOR s[0]) == 0, i.e. the final coefficient sum must be odd.
  - Accept: mem[idx] <= s[7:0]; idx++; mod2 ^= s[0]; sq_norm += s*s.
  - Reject: rej_cnt++ (saturating). idx, mod2 and the buffer are unchanged.
- in_valid is ignored in IDLE and DONE, and in any cycle where start is high.
- Storage: N x 8 array, one write port and one read port. It is not reset.
- Readout: rd_data <= mem[rd_addr] every cycle, in any state. A read and write to the same address in one cycle returns the old data.

## Timing

- Reset values: need=0, busy=0, done=0, rej_cnt=0, sq_norm=0, rd_data=0. State is IDLE.
- need/busy rise the cycle after start is sampled and fall the cycle after the last accept.
- done is high for exactly the cycle in state DONE, i.e. one cycle after the last accepted sample is sampled.
- rej_cnt and sq_norm update one cycle after the sample. Both are final and stable while done is high and hold until the next start or rst.
- Read latency is 1 cycle.
- No backpressure. Back-to-back in_valid is accepted at one sample per cycle.
- rst mid-COLLECT aborts: outputs return to reset values and no done is produced.
- start in the DONE cycle: done still pulses, and the next state is COLLECT.

## Configuration

- GAUSS_POLY_NORM_EN defined: sq_norm is computed as above. Width rule: 127^2 * 1024 < 2^24, so no overflow is possible in 32 bits.
- Not defined: the squarer and accumulator are omitted, and sq_norm is tied to 0.

## Test plan

- logn=2, start, then samples 3, -1, 0, 2, 5:
  - 2 is rejected on parity.
  - Required: done one cycle after 5 is sampled; rej_cnt=1; sq_norm=35.
  - Readout of addresses 0..3 gives 3, -1, 0, 5 with 1-cycle latency.
- Range, logn=2: samples -128, 128, 200, -127, 127, 0, 1:
  - rej_cnt=3; buffer holds -127, 127, 0, 1; sq_norm=32259.
- Restart, logn=3: start, 5 accepted samples, then start, then 8 legal samples:
  - Exactly one done pulse; rej_cnt counts only after the second start.
  - The buffer holds the second set of samples.
- Ignore and abort:
  - in_valid pulses in IDLE leave rej_cnt=0 and produce no done.
  - rst after 3 accepts clears all outputs next cycle; no done follows.
- logn=9 stream with random gaps, including 300 back-to-back samples from a sampler model:
  - done after exactly 512 accepts.
  - Sum of the buffer is odd; every coefficient is within ±127.
  - sq_norm matches the model (0 when GAUSS_POLY_NORM_EN is undefined).
